// File: rtl/cnn_conv1_mac_ctrl_if.sv
// Bundle for the conv1 MAC controller: start/idle/done control, the two
// operand streams, the external multiplier hook-up and the result stream.
// slave  = the controller's view, master = the surrounding system's view.
interface cnn_conv1_mac_ctrl_if #(
  parameter int ACC_W = 26
);
  logic                     ap_start;
  logic                     ap_idle;
  logic                     ap_done;
  logic        [4:0]        klen;
  logic signed [9:0]        w_data;
  logic                     w_valid;
  logic signed [13:0]       x_data;
  logic                     x_valid;
  logic                     op_ready;
  logic signed [9:0]        mul_a;
  logic signed [13:0]       mul_b;
  logic signed [24:0]       mul_p;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     acc_valid;
  logic                     acc_ready;

  modport master (
    output ap_start, klen, w_data, w_valid, x_data, x_valid, mul_p, acc_ready,
    input  ap_idle, ap_done, op_ready, mul_a, mul_b, acc_out, acc_valid
  );

  modport slave (
    input  ap_start, klen, w_data, w_valid, x_data, x_valid, mul_p, acc_ready,
    output ap_idle, ap_done, op_ready, mul_a, mul_b, acc_out, acc_valid
  );
endinterface

// File: rtl/cnn_conv1_mac_ctrl.sv
// Dot-product controller for the first conv layer. Accepts up to 25
// (weight, pixel) pairs, feeds them through an external 10x14 multiplier
// with a two-stage pipeline (operand reg -> product reg -> accumulate) and
// presents the sum on a valid/ready result port.
// Optional feature: define CNN_MAC_SAT_EN for a saturating, sticky-clamp
// accumulator; otherwise the accumulator wraps in two's complement.
module cnn_conv1_mac_ctrl #(
  parameter int ACC_W = 26
) (
  input logic                 ap_clk,
  input logic                 ap_rst_n,
  cnn_conv1_mac_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                  state, state_nxt;
  logic        [4:0]       klen_q;
  logic        [4:0]       cnt;
  logic        [4:0]       klen_clamped;
  logic                    drain_cnt;
  logic                    stage1_vld;
  logic                    stage2_vld;
  logic signed [24:0]      prod_q;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [9:0]       mul_a_q;
  logic signed [13:0]      mul_b_q;
  logic                    start_ok;
  logic                    op_rdy;
  logic                    fire;
  logic                    last_fire;

  assign klen_clamped = (bus.klen > 5'd25) ? 5'd25 : bus.klen;
  assign start_ok     = (state == IDLE) && bus.ap_start;
  assign op_rdy       = (state == RUN) && (cnt < klen_q);
  assign fire         = op_rdy && bus.w_valid && bus.x_valid;
  assign last_fire    = fire && ((cnt + 5'd1) == klen_q);
  assign prod_ext     = ACC_W'(prod_q);

`ifdef CNN_MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;
  logic           overflow;
  logic           sat_q;

  // Saturating add: once clamped the accumulator holds until the next start
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    overflow = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (sat_q) begin
      acc_next = acc;
    end else if (overflow) begin
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum_wide[ACC_W-1:0];
    end
  end

  // Sticky clamp flag, cleared by every accepted start
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_q <= 1'b0;
    end else if (start_ok) begin
      sat_q <= 1'b0;
    end else if (stage2_vld && overflow) begin
      sat_q <= 1'b1;
    end
  end
`else
  // Plain two's complement wrap-around accumulate
  always_comb begin
    acc_next = acc + prod_ext;
  end
`endif

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DRAIN covers the two pipeline stages behind the last pair
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.ap_start) state_nxt = (klen_clamped == 5'd0) ? OUT : RUN;
      RUN:   if (last_fire) state_nxt = DRAIN;
      DRAIN: if (drain_cnt) state_nxt = OUT;
      OUT:   if (bus.acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    bus.ap_idle   = 1'b0;
    bus.op_ready  = 1'b0;
    bus.acc_valid = 1'b0;
    bus.ap_done   = 1'b0;
    case (state)
      IDLE: bus.ap_idle = 1'b1;
      RUN:  bus.op_ready = op_rdy;
      OUT: begin
        bus.acc_valid = 1'b1;
        bus.ap_done   = bus.acc_ready;
      end
      default: ;
    endcase
  end

  // Length capture, accept counter and drain timer
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      klen_q    <= 5'd0;
      cnt       <= 5'd0;
      drain_cnt <= 1'b0;
    end else begin
      if (start_ok) begin
        klen_q <= klen_clamped;
        cnt    <= 5'd0;
      end else if (fire) begin
        cnt <= cnt + 5'd1;
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Multiply pipeline: operands on accept, product one cycle later
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      stage1_vld <= 1'b0;
      stage2_vld <= 1'b0;
      prod_q     <= '0;
    end else begin
      if (fire) begin
        mul_a_q <= bus.w_data;
        mul_b_q <= bus.x_data;
      end
      stage1_vld <= fire;
      stage2_vld <= stage1_vld;
      if (stage1_vld) begin
        prod_q <= bus.mul_p;
      end
    end
  end

  // Accumulator: cleared on start, adds each registered product once
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc <= '0;
    end else if (start_ok) begin
      acc <= '0;
    end else if (stage2_vld) begin
      acc <= acc_next;
    end
  end

  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
  assign bus.acc_out = acc;

endmodule

// File: doc/cnn_conv1_mac_ctrl.md
CNN_CONV1_MAC_CTRL -- requirements
Module: cnn_conv1_mac_ctrl

Interface
REQ-001 Parameter ACC_W, default 26: accumulator and result width in bits, legal range 25..40.
REQ-002 ap_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 ap_rst_n  in  1  asynchronous, active-low reset.
REQ-004 ap_start  in  1  request to begin one dot product; sampled only in IDLE.
REQ-005 ap_idle  out  1  high exactly when the FSM is in IDLE.
REQ-006 ap_done  out  1  one-cycle pulse on the cycle the result handshake completes.
REQ-007 klen  in  5  number of operand pairs, 0..25; captured on an accepted ap_start.
REQ-008 w_data  in  10  signed weight.
REQ-009 w_valid  in  1  weight present.
REQ-010 x_data  in  14  signed pixel.
REQ-011 x_valid  in  1  pixel present.
REQ-012 op_ready  out  1  shared ready for both operand streams.
REQ-013 mul_a  out  10  registered operand to the external signed 10x14 multiplier.
REQ-014 mul_b  out  14  registered operand to the external multiplier.
REQ-015 mul_p  in  25  combinational signed product returned by the multiplier.
REQ-016 acc_out  out  ACC_W  signed dot-product result.
REQ-017 acc_valid  out  1  result present.
REQ-018 acc_ready  in  1  consumer accepts the result.

Function
REQ-019 States: IDLE, RUN, DRAIN, OUT.
REQ-020 IDLE->RUN on ap_start with klen>0; IDLE->OUT on ap_start with klen=0, acc_out=0.
REQ-021 op_ready is high only in RUN while the accepted count is below the captured klen.
REQ-022 A pair transfers only when w_valid, x_valid and op_ready are all high in the same cycle; a lone valid never transfers.
REQ-023 On a transfer at edge t: mul_a/mul_b load the pair at t; the product is registered at t+1; it is added to the accumulator at t+2.
REQ-024 The pipeline accepts one pair per cycle with no bubbles.
REQ-025 RUN->DRAIN on the edge that accepts the klen-th pair; DRAIN lasts exactly 2 cycles, then ->OUT.
REQ-026 The accumulator clears to 0 on every accepted ap_start.
REQ-027 Each product is sign-extended to ACC_W before addition.
REQ-028 In OUT, acc_valid is high and acc_out is stable until acc_ready; on that handshake: ->IDLE, ap_done pulses for 1 cycle.
REQ-029 ap_start outside IDLE is ignored; changes to klen after capture are ignored.
REQ-030 klen>25 is clamped to 25.

Reset
REQ-031 While ap_rst_n=0: FSM=IDLE, ap_idle=1, ap_done=0, op_ready=0, acc_valid=0, acc_out=0, mul_a=0, mul_b=0, accumulator/count/pipeline registers=0.
REQ-032 Reset asserted mid-operation aborts immediately; in-flight products are discarded; no ap_done is issued.

Configuration
REQ-033 Macro CNN_MAC_SAT_EN defined: each accumulate saturates to +(2^(ACC_W-1)-1) / -2^(ACC_W-1) and stays clamped until the next start.
REQ-034 Macro absent: the accumulate wraps modulo 2^ACC_W (two's complement).

Verification
REQ-035 klen=3; pairs (1,2),(-3,4),(5,-6), all valid every cycle -> op_ready high 3 cycles; acc_out=-40 appears 3 cycles after the last accept; one ap_done.
REQ-036 klen=0 with ap_start -> acc_valid next cycle, acc_out=0; no operands consumed.
REQ-037 klen=2; x_valid held low 4 cycles while w_valid=1 -> no transfer and no count change; acc_out=(w0*x0+w1*x1) once x arrives.
REQ-038 acc_ready held low 5 cycles in OUT -> acc_valid and acc_out stable; ap_start pulses ignored; ap_done asserts only on the handshake cycle.
REQ-039 ACC_W=26, klen=25, every pair (-512,-8192) -> with CNN_MAC_SAT_EN acc_out=33554431; without it acc_out=104857600 mod 2^26 = 37748736 interpreted signed = -29360128.
REQ-040 ap_rst_n pulsed low after the 2nd of 5 accepts -> all outputs at reset values; a following start with klen=1 and pair (7,7) yields 49.
